pic_mask_unit: RTL and testbench

//  Clocked, parametrised interrupt mask unit for the PIC. Holds NUM_IR mask bits written

---
 rtl/pic_mask_unit_pkg.sv | 24 ++
 rtl/pic_mask_unit_if.sv | 37 +++
 rtl/pic_mask_unit_lane.sv | 31 +++
 rtl/pic_mask_unit.sv | 89 ++++++++
 tb/tb_pic_mask_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pic_mask_unit_pkg.sv
// Shared constants and helpers for the PIC interrupt mask unit.
//   DATA_W_DEF      default internal data bus / OCW1 lane width
//   OCW3_ESMM_BIT   OCW3 bit that enables a special-mask-mode update
//   OCW3_SMM_BIT    OCW3 bit that carries the special-mask-mode value
//   lane_w()        lane-select width for a given channel count and lane width
package pic_mask_unit_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int OCW3_ESMM_BIT = 6;
    localparam int OCW3_SMM_BIT  = 5;

    // Lane-select width, never narrower than one bit.
    function automatic int lane_w(input int num_ir, input int data_w);
        int n;
        int w;
        n = num_ir / data_w;
        w = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << k) < n) w = k + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pic_mask_unit_if.sv
// Control-bus interface between the PIC control logic (master) and the mask unit (slave).
//   icw1_init, ocw1_wr/lane/data, ocw3_wr/esmm/smm   write strobes and payload
//   read_imr, read_lane                             IMR read-back request
//   data_out, data_oe                               registered read-back data and enable
interface pic_mask_unit_if
    import pic_mask_unit_pkg::*;
#(
    parameter int NUM_IR = 8,
    parameter int DATA_W = DATA_W_DEF
);
    localparam int LANE_W = lane_w(NUM_IR, DATA_W);

    logic              icw1_init;
    logic              ocw1_wr;
    logic [LANE_W-1:0] ocw1_lane;
    logic [DATA_W-1:0] ocw1_data;
    logic              ocw3_wr;
    logic              ocw3_esmm;
    logic              ocw3_smm;
    logic              read_imr;
    logic [LANE_W-1:0] read_lane;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;

    modport master (
        output icw1_init, ocw1_wr, ocw1_lane, ocw1_data,
        output ocw3_wr, ocw3_esmm, ocw3_smm, read_imr, read_lane,
        input  data_out, data_oe
    );

    modport slave (
        input  icw1_init, ocw1_wr, ocw1_lane, ocw1_data,
        input  ocw3_wr, ocw3_esmm, ocw3_smm, read_imr, read_lane,
        output data_out, data_oe
    );

endinterface

// File: rtl/pic_mask_unit_lane.sv
// One DATA_W-bit lane of the interrupt mask register.
//   clk, reset   clock and synchronous active-high reset (loads RST_VAL)
//   clr          clears the lane; wins over wr_en
//   wr_en        loads wr_data
//   mask_q       current lane mask bits
module pic_mask_lane #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] mask_q
);

    logic [DATA_W-1:0] mask_d;

    always_comb begin
        mask_d = mask_q;
        if (clr)        mask_d = '0;
        else if (wr_en) mask_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) mask_q <= RST_VAL;
        else       mask_q <= mask_d;
    end

endmodule

// File: rtl/pic_mask_unit.sv
// PIC interrupt mask unit: lane-written IMR, 8259A special mask mode and registered read-back.
//   clk, reset      clock and synchronous active-high reset
//   bus             control-bus slave (OCW1/OCW3/ICW1 strobes, IMR read port)
//   irr_raw, isr    raw requests and in-service bits
//   imr_reg         current mask register
//   irr_masked      irr_raw with masked channels removed
//   isr_effective   isr, with masked channels hidden while special mask mode is on
//   special_mask    special mask mode flag
module pic_mask_unit
    import pic_mask_unit_pkg::*;
#(
    parameter int                NUM_IR     = 8,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [NUM_IR-1:0] RESET_MASK = {NUM_IR{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    pic_mask_unit_if.slave    bus,
    input  logic [NUM_IR-1:0] irr_raw,
    input  logic [NUM_IR-1:0] isr,
    output logic [NUM_IR-1:0] imr_reg,
    output logic [NUM_IR-1:0] irr_masked,
    output logic [NUM_IR-1:0] isr_effective,
    output logic              special_mask
);

    localparam int NUM_LANES = NUM_IR / DATA_W;
    localparam int LANE_W    = lane_w(NUM_IR, DATA_W);

    logic              special_mask_q, special_mask_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic [DATA_W-1:0] rd_data;

    // Out-of-range lanes match no generate index, so such writes are dropped.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic lane_we;
        assign lane_we = bus.ocw1_wr & ~bus.icw1_init & (bus.ocw1_lane == LANE_W'(g));

        pic_mask_lane #(
            .DATA_W  (DATA_W),
            .RST_VAL (RESET_MASK[g*DATA_W +: DATA_W])
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clr     (bus.icw1_init),
            .wr_en   (lane_we),
            .wr_data (bus.ocw1_data),
            .mask_q  (imr_reg[g*DATA_W +: DATA_W])
        );
    end

    // Out-of-range read lanes fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.read_lane == LANE_W'(i)) rd_data = imr_reg[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        special_mask_d = special_mask_q;
        if (bus.icw1_init)                    special_mask_d = 1'b0;
        else if (bus.ocw3_wr && bus.ocw3_esmm) special_mask_d = bus.ocw3_smm;

        // Read uses the pre-write IMR, so a same-cycle write shows up one cycle later.
        data_oe_d  = bus.read_imr;
        data_out_d = bus.read_imr ? rd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            special_mask_q <= 1'b0;
            data_out_q     <= '0;
            data_oe_q      <= 1'b0;
        end else begin
            special_mask_q <= special_mask_d;
            data_out_q     <= data_out_d;
            data_oe_q      <= data_oe_d;
        end
    end

    assign special_mask  = special_mask_q;
    assign bus.data_out  = data_out_q;
    assign bus.data_oe   = data_oe_q;
    assign irr_masked    = irr_raw & ~imr_reg;
    assign isr_effective = special_mask_q ? (isr & ~imr_reg) : isr;

endmodule

// File: tb/tb_pic_mask_unit.sv
// Directed bench for pic_mask_unit: an 8-channel and a 16-channel instance share clock and reset.
module tb_pic_mask_unit;

    logic clk;
    logic reset;

    logic [7:0]  irr8, isr8, imr8, irrm8, isre8;
    logic        sm8;
    logic [15:0] irr16, isr16, imr16, irrm16, isre16;
    logic        sm16;

    pic_mask_unit_if #(.NUM_IR(8),  .DATA_W(8)) if8 ();
    pic_mask_unit_if #(.NUM_IR(16), .DATA_W(8)) if16 ();

    pic_mask_unit #(.NUM_IR(8), .DATA_W(8)) dut8 (
        .clk           (clk),
        .reset         (reset),
        .bus           (if8),
        .irr_raw       (irr8),
        .isr           (isr8),
        .imr_reg       (imr8),
        .irr_masked    (irrm8),
        .isr_effective (isre8),
        .special_mask  (sm8)
    );

    pic_mask_unit #(.NUM_IR(16), .DATA_W(8)) dut16 (
        .clk           (clk),
        .reset         (reset),
        .bus           (if16),
        .irr_raw       (irr16),
        .isr           (isr16),
        .imr_reg       (imr16),
        .irr_masked    (irrm16),
        .isr_effective (isre16),
        .special_mask  (sm16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [15:0] v);
        sb_q.push_back('{tag, v});
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        irr8 = '0; isr8 = '0; irr16 = '0; isr16 = '0;
        if8.icw1_init = 0; if8.ocw1_wr = 0; if8.ocw1_lane = '0; if8.ocw1_data = '0;
        if8.ocw3_wr = 0; if8.ocw3_esmm = 0; if8.ocw3_smm = 0; if8.read_imr = 0; if8.read_lane = '0;
        if16.icw1_init = 0; if16.ocw1_wr = 0; if16.ocw1_lane = '0; if16.ocw1_data = '0;
        if16.ocw3_wr = 0; if16.ocw3_esmm = 0; if16.ocw3_smm = 0; if16.read_imr = 0; if16.read_lane = '0;

        // Reset state
        irr8 = 8'hFF;
        irr16 = 16'hFFFF;
        push("rst_imr8", 16'h00FF);
        push("rst_sm8", 16'h0000);
        push("rst_oe8", 16'h0000);
        push("rst_dout8", 16'h0000);
        push("rst_irrm8", 16'h0000);
        push("rst_imr16", 16'hFFFF);
        tick(); tick();
        check({8'h00, imr8});
        check({15'h0, sm8});
        check({15'h0, if8.data_oe});
        check({8'h00, if8.data_out});
        check({8'h00, irrm8});
        check(imr16);
        reset = 1'b0;
        tick();

        // OCW1 lane 0 = A5; old mask still visible before the edge
        if8.ocw1_wr = 1; if8.ocw1_lane = 1'b0; if8.ocw1_data = 8'hA5;
        push("wr_latency_imr8", 16'h00FF);
        check({8'h00, imr8});
        push("wr_imr8", 16'h00A5);
        push("wr_irrm8", 16'h005A);
        tick();
        if8.ocw1_wr = 0;
        check({8'h00, imr8});
        check({8'h00, irrm8});

        // 16 channels: write lane 1 = 0F, read back lanes 1 and 0
        if16.ocw1_wr = 1; if16.ocw1_lane = 1'b1; if16.ocw1_data = 8'h0F;
        tick();
        if16.ocw1_wr = 0;
        push("imr16_lane1", 16'h0FFF);
        check(imr16);
        if16.read_imr = 1; if16.read_lane = 1'b1;
        push("rd16_oe", 16'h0001);
        push("rd16_lane1", 16'h000F);
        tick();
        check({15'h0, if16.data_oe});
        check({8'h00, if16.data_out});
        if16.read_lane = 1'b0;
        push("rd16_lane0", 16'h00FF);
        tick();
        check({8'h00, if16.data_out});
        if16.read_imr = 0;

        // 8 channels: lane 1 is out of range for both read and write
        if8.read_imr = 1; if8.read_lane = 1'b1;
        if8.ocw1_wr = 1; if8.ocw1_lane = 1'b1; if8.ocw1_data = 8'h00;
        push("rd8_oor_oe", 16'h0001);
        push("rd8_oor_data", 16'h0000);
        push("wr8_oor_dropped", 16'h00A5);
        tick();
        if8.ocw1_wr = 0; if8.read_imr = 0;
        check({15'h0, if8.data_oe});
        check({8'h00, if8.data_out});
        check({8'h00, imr8});

        // Special mask mode
        if8.ocw1_wr = 1; if8.ocw1_lane = 1'b0; if8.ocw1_data = 8'h04;
        isr8 = 8'h06;
        tick();
        if8.ocw1_wr = 0;
        push("isre_normal", 16'h0006);
        check({8'h00, isre8});
        if8.ocw3_wr = 1; if8.ocw3_esmm = 1; if8.ocw3_smm = 1;
        push("smm_set", 16'h0001);
        push("isre_smm", 16'h0002);
        tick();
        check({15'h0, sm8});
        check({8'h00, isre8});
        if8.ocw3_esmm = 0; if8.ocw3_smm = 0;
        push("smm_hold_esmm0", 16'h0001);
        tick();
        if8.ocw3_wr = 0;
        check({15'h0, sm8});

        // Same-cycle write and read of lane 0
        if8.ocw1_wr = 1; if8.ocw1_data = 8'hA5;
        tick();
        if8.ocw1_data = 8'h00;
        if8.read_imr = 1; if8.read_lane = 1'b0;
        push("rw_same_old", 16'h00A5);
        push("rw_same_imr", 16'h0000);
        tick();
        if8.ocw1_wr = 0;
        check({8'h00, if8.data_out});
        check({8'h00, imr8});
        push("rw_same_new", 16'h0000);
        tick();
        check({8'h00, if8.data_out});
        if8.read_imr = 0;
        push("rd_release_oe", 16'h0000);
        tick();
        check({15'h0, if8.data_oe});

        // ICW1 init beats concurrent OCW1/OCW3 writes
        if8.ocw1_wr = 1; if8.ocw1_data = 8'h3C;
        tick();
        if8.icw1_init = 1; if8.ocw1_data = 8'hFF;
        if8.ocw3_wr = 1; if8.ocw3_esmm = 1; if8.ocw3_smm = 1;
        push("icw1_imr", 16'h0000);
        push("icw1_sm", 16'h0000);
        tick();
        if8.icw1_init = 0; if8.ocw1_wr = 0; if8.ocw3_wr = 0; if8.ocw3_esmm = 0; if8.ocw3_smm = 0;
        check({8'h00, imr8});
        check({15'h0, sm8});

        // Reset during an active read
        if8.read_imr = 1; if8.read_lane = 1'b0;
        push("rd_before_rst_oe", 16'h0001);
        tick();
        check({15'h0, if8.data_oe});
        reset = 1'b1;
        push("rst_mid_rd_oe", 16'h0000);
        push("rst_mid_rd_dout", 16'h0000);
        push("rst_mid_rd_imr", 16'h00FF);
        tick();
        check({15'h0, if8.data_oe});
        check({8'h00, if8.data_out});
        check({8'h00, imr8});
        reset = 1'b0;
        if8.read_imr = 0;
        tick();

        if (sb_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
